// File: rtl/operand_entry_pkg.sv
// Shared constants and state encoding for the calculator operand entry front end.
package operand_entry_pkg;

  localparam int WIDTH_DEF           = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 500000;

  typedef enum logic [1:0] {
    ST_WAIT_A = 2'd0,
    ST_WAIT_B = 2'd1,
    ST_VALID  = 2'd2
  } entry_state_t;

endpackage

// File: rtl/operand_entry_debouncer.sv
// Push-button conditioner: 2-flop synchroniser, stability counter, and a one-cycle
// pulse on each accepted press (debounced 1->0). Releases produce no pulse.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;
  logic          press;

  // stage p0/p1: bring the asynchronous button into the clock domain
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= i_btn_n;
      sync_p1 <= sync_p0;
    end
  end

  // level only follows the synced input after it has disagreed for DEBOUNCE_CYCLES edges
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_p1 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_p1;
          cnt   <= '0;
          press <= level;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_level = level;
  assign o_press = press;

endmodule

// File: rtl/operand_entry.sv
// Operand entry front end: debounced ENTER captures A then B, the pair is offered
// downstream under valid/ready, and a debounced CLEAR returns to the start.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int WIDTH           = WIDTH_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_key_n,
  input  logic             i_clear_n,
  input  logic [WIDTH-1:0] i_sw,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_valid,
  output logic [1:0]       o_stage
);

  logic key_level;
  logic key_press;
  logic clear_level;
  logic clear_press;
  logic key_evt;
  logic clear_evt;

  entry_state_t     state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             valid_q;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_db (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn_n (i_key_n),
    .o_level (key_level),
    .o_press (key_press)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_clear_db (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_btn_n (i_clear_n),
    .o_level (clear_level),
    .o_press (clear_press)
  );

  // A press pulse always coincides with a low debounced level; qualifying on it
  // keeps a stray pulse from acting while the button reads released.
  assign key_evt   = key_press   & ~key_level;
  assign clear_evt = clear_press & ~clear_level;

  // Priority: reset, then clear, then handshake transfer, then press.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else if (clear_evt) begin
      state   <= ST_WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_A: begin
          if (key_evt) begin
            a_q   <= i_sw;
            state <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (key_evt) begin
            b_q     <= i_sw;
            state   <= ST_VALID;
            valid_q <= 1'b1;
          end
        end
        ST_VALID: begin
          if (i_ready) begin
            state   <= ST_WAIT_A;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state   <= ST_WAIT_A;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_a     = a_q;
  assign o_b     = b_q;
  assign o_valid = valid_q;
  assign o_stage = state;

endmodule

// File: tb/tb_operand_entry.sv
// Scenario bench for operand_entry with a short debounce window.
module tb_operand_entry;

  localparam int W  = 4;
  localparam int DC = 4;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_key_n = 1'b1;
  logic         i_clear_n = 1'b1;
  logic [W-1:0] i_sw = '0;
  logic         i_ready = 1'b1;
  logic [W-1:0] o_a;
  logic [W-1:0] o_b;
  logic         o_valid;
  logic [1:0]   o_stage;

  int passed = 0;
  int total  = 0;
  logic [2*W-1:0] sb_q[$];

  operand_entry #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_key_n   (i_key_n),
    .i_clear_n (i_clear_n),
    .i_sw      (i_sw),
    .i_ready   (i_ready),
    .o_a       (o_a),
    .o_b       (o_b),
    .o_valid   (o_valid),
    .o_stage   (o_stage)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic press_key(input logic [W-1:0] sw);
    i_sw = sw;
    i_key_n = 1'b0;
    repeat (DC + 4) tick();
    i_key_n = 1'b1;
    repeat (DC + 4) tick();
  endtask

  task automatic press_clear();
    i_clear_n = 1'b0;
    repeat (DC + 4) tick();
    i_clear_n = 1'b1;
    repeat (DC + 4) tick();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (o_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic pop_and_compare(input string name);
    bit ok;
    logic [2*W-1:0] exp;
    wait_valid(ok);
    total++;
    if (!ok) $display("FAIL %s_timeout: o_valid=%b want 1 within 50 cycles", name, o_valid);
    else passed++;
    if (sb_q.size() == 0) begin
      total++;
      $display("FAIL %s_sb_empty: queue size 0 want >0", name);
    end else begin
      exp = sb_q.pop_front();
      total++;
      if ({o_a, o_b} !== exp) $display("FAIL %s_pair: got %h want %h", name, {o_a, o_b}, exp);
      else passed++;
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_key_n = 1'b0;
    i_clear_n = 1'b0;
    i_sw = 4'hC;
    repeat (8) tick();
    total++;
    if ({o_a, o_b, o_valid, o_stage} !== 11'd0)
      $display("FAIL reset_outputs: got a=%h b=%h v=%b st=%0d want all 0", o_a, o_b, o_valid, o_stage);
    else passed++;
    i_key_n = 1'b1;
    i_clear_n = 1'b1;
    tick();
    i_rst_n = 1'b1;
    repeat (12) tick();
    total++;
    if (o_stage !== 2'd0 || o_a !== 4'h0)
      $display("FAIL reset_no_event: got st=%0d a=%h want st=0 a=0", o_stage, o_a);
    else passed++;
  endtask

  task automatic test_full_transaction();
    bit bad;
    i_ready = 1'b0;
    press_key(4'h9);
    press_key(4'h7);
    sb_q.push_back({4'h9, 4'h7});
    pop_and_compare("full");
    total++;
    if (o_stage !== 2'd2) $display("FAIL full_stage: got %0d want 2", o_stage);
    else passed++;
    bad = 1'b0;
    repeat (10) begin
      tick();
      if (o_valid !== 1'b1 || o_stage !== 2'd2 || o_a !== 4'h9 || o_b !== 4'h7) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL full_hold: got v=%b st=%0d a=%h b=%h want held 1/2/9/7", o_valid, o_stage, o_a, o_b);
    else passed++;
    i_ready = 1'b1;
    tick();
    total++;
    if (o_valid !== 1'b0 || o_stage !== 2'd0)
      $display("FAIL full_transfer: got v=%b st=%0d want v=0 st=0", o_valid, o_stage);
    else passed++;
    total++;
    if (o_a !== 4'h9 || o_b !== 4'h7)
      $display("FAIL full_keep: got a=%h b=%h want 9/7", o_a, o_b);
    else passed++;
  endtask

  task automatic test_debounce();
    i_ready = 1'b0;
    i_sw = 4'h3;
    for (int n = 1; n <= 3; n++) begin
      i_key_n = 1'b0;
      repeat (n) tick();
      i_key_n = 1'b1;
      repeat (6) tick();
    end
    total++;
    if (o_stage !== 2'd0 || o_a !== 4'h9)
      $display("FAIL glitch_reject: got st=%0d a=%h want st=0 a=9", o_stage, o_a);
    else passed++;
    i_key_n = 1'b0;
    repeat (6) tick();
    total++;
    if (o_stage !== 2'd0 || o_a !== 4'h9)
      $display("FAIL latency_early: got st=%0d a=%h want st=0 a=9", o_stage, o_a);
    else passed++;
    tick();
    total++;
    if (o_stage !== 2'd1 || o_a !== 4'h3)
      $display("FAIL latency_exact: got st=%0d a=%h want st=1 a=3", o_stage, o_a);
    else passed++;
    i_key_n = 1'b1; tick();
    i_key_n = 1'b0; tick();
    i_key_n = 1'b1; tick(); tick();
    i_key_n = 1'b0; tick();
    i_key_n = 1'b1;
    repeat (12) tick();
    total++;
    if (o_stage !== 2'd1 || o_b !== 4'h7)
      $display("FAIL bounce_release: got st=%0d b=%h want st=1 b=7", o_stage, o_b);
    else passed++;
    press_key(4'h4);
    sb_q.push_back({4'h3, 4'h4});
    pop_and_compare("debounce");
  endtask

  task automatic test_press_in_valid();
    press_key(4'hF);
    total++;
    if (o_a !== 4'h3 || o_b !== 4'h4 || o_stage !== 2'd2 || o_valid !== 1'b1)
      $display("FAIL valid_press: got a=%h b=%h st=%0d v=%b want 3/4/2/1", o_a, o_b, o_stage, o_valid);
    else passed++;
    i_ready = 1'b1;
    tick();
    total++;
    if (o_stage !== 2'd0 || o_valid !== 1'b0)
      $display("FAIL valid_release: got st=%0d v=%b want 0/0", o_stage, o_valid);
    else passed++;
    i_ready = 1'b0;
  endtask

  task automatic test_clear();
    press_key(4'h5);
    total++;
    if (o_stage !== 2'd1 || o_a !== 4'h5)
      $display("FAIL clear_setup: got st=%0d a=%h want 1/5", o_stage, o_a);
    else passed++;
    press_clear();
    total++;
    if (o_stage !== 2'd0 || o_a !== 4'h0 || o_b !== 4'h0)
      $display("FAIL clear_wait_b: got st=%0d a=%h b=%h want 0/0/0", o_stage, o_a, o_b);
    else passed++;
    press_key(4'h6);
    i_sw = 4'h8;
    i_key_n = 1'b0;
    i_clear_n = 1'b0;
    repeat (DC + 4) tick();
    i_key_n = 1'b1;
    i_clear_n = 1'b1;
    repeat (DC + 4) tick();
    total++;
    if (o_stage !== 2'd0 || o_a !== 4'h0 || o_b !== 4'h0)
      $display("FAIL clear_vs_press: got st=%0d a=%h b=%h want 0/0/0", o_stage, o_a, o_b);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit bad;
    i_ready = 1'b0;
    press_key(4'h1);
    press_key(4'h2);
    sb_q.push_back({4'h1, 4'h2});
    pop_and_compare("rstmid");
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    total++;
    if ({o_a, o_b, o_valid, o_stage} !== 11'd0)
      $display("FAIL rstmid_outputs: got a=%h b=%h v=%b st=%0d want all 0", o_a, o_b, o_valid, o_stage);
    else passed++;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (o_valid !== 1'b0 || o_stage !== 2'd0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL rstmid_stay: got v=%b st=%0d want 0/0", o_valid, o_stage);
    else passed++;
    i_sw = 4'hA;
    i_key_n = 1'b0;
    repeat (3) tick();
    i_rst_n = 1'b0;
    tick();
    i_rst_n = 1'b1;
    repeat (6) tick();
    total++;
    if (o_stage !== 2'd0) $display("FAIL rstdb_early: got st=%0d want 0", o_stage);
    else passed++;
    tick();
    total++;
    if (o_stage !== 2'd1 || o_a !== 4'hA)
      $display("FAIL rstdb_exact: got st=%0d a=%h want 1/a", o_stage, o_a);
    else passed++;
    i_key_n = 1'b1;
    repeat (DC + 4) tick();
  endtask

  initial begin
    test_reset();
    test_full_transaction();
    test_debounce();
    test_press_in_valid();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
